// File: rtl/zet_ifetch_asm_pkg.sv
// zet_ifetch_asm_pkg: shared state encoding, prefix bytes and length limit for the instruction assembler.
package zet_ifetch_asm_pkg;
   typedef enum logic [2:0] {
      S_OPC, S_MODRM, S_CHK, S_OFF_LO, S_OFF_HI, S_IMM_LO, S_IMM_HI, S_EXEC
   } state_t;
   localparam int MAX_LEN_DEF = 15;
   localparam logic [7:0] PFX_REP   = 8'hF3;
   localparam logic [7:0] PFX_REPNE = 8'hF2;
   localparam logic [7:0] PFX_LOCK  = 8'hF0;
   localparam logic [7:0] PFX_ES    = 8'h26;
   localparam logic [7:0] PFX_CS    = 8'h2E;
   localparam logic [7:0] PFX_SS    = 8'h36;
   localparam logic [7:0] PFX_DS    = 8'h3E;
endpackage

// File: rtl/zet_ifetch_pfx.sv
// zet_ifetch_pfx: combinational prefix classifier for the head queue byte.
// is_lock_o exists only when ZET_IFETCH_LOCK_EN is defined.
module zet_ifetch_pfx
   import zet_ifetch_asm_pkg::*;
(
   input  logic [7:0] b_i,
   output logic       is_prefix_o,
   output logic       is_rep_o,
`ifdef ZET_IFETCH_LOCK_EN
   output logic       is_lock_o,
`endif
   output logic       seg_valid_o,
   output logic [1:0] seg_o
);
   always_comb begin
      is_rep_o    = (b_i == PFX_REP) || (b_i == PFX_REPNE);
      seg_valid_o = (b_i == PFX_ES) || (b_i == PFX_CS) || (b_i == PFX_SS) || (b_i == PFX_DS);
      // 26/2E/36/3E encode the segment number in bits [4:3]
      seg_o       = b_i[4:3];
      is_prefix_o = is_rep_o || seg_valid_o || (b_i == PFX_LOCK);
`ifdef ZET_IFETCH_LOCK_EN
      is_lock_o   = (b_i == PFX_LOCK);
`endif
   end
endmodule

// File: rtl/zet_ifetch_asm.sv
// zet_ifetch_asm: assembles prefixes, opcode, ModR/M, displacement and immediate for the decoder.
// Define ZET_IFETCH_LOCK_EN to add the lock output driven by the F0 prefix.
module zet_ifetch_asm
   import zet_ifetch_asm_pkg::*;
#(
   parameter int MAX_LEN = MAX_LEN_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  q_byte,
   input  logic        q_valid,
   output logic        q_pop,
   input  logic        flush,
   input  logic        need_modrm,
   input  logic        need_off,
   input  logic        need_imm,
   input  logic        off_size,
   input  logic        imm_size,
   input  logic        end_seq,
   input  logic        block,
   output logic [7:0]  opcode,
   output logic [7:0]  modrm,
   output logic [15:0] off,
   output logic [15:0] imm,
   output logic        rep,
   output logic [2:0]  sop_l,
   output logic        exec_st,
`ifdef ZET_IFETCH_LOCK_EN
   output logic        lock,
`endif
   output logic [3:0]  inst_len
);
   state_t      state_q, state_d;
   logic [7:0]  opcode_q, opcode_d, modrm_q, modrm_d;
   logic [15:0] off_q, off_d, imm_q, imm_d;
   logic        rep_q, rep_d;
   logic [2:0]  sop_q, sop_d;
   logic [3:0]  len_q, len_d, len_inc;
   logic        pf_prefix, pf_rep, pf_seg_v, consume;
   logic [1:0]  pf_seg;
   state_t      field_nxt, imm_nxt;
`ifdef ZET_IFETCH_LOCK_EN
   logic        pf_lock, lock_q, lock_d;
   assign lock = lock_q;
`endif

   zet_ifetch_pfx u_pfx (
      .b_i         (q_byte),
      .is_prefix_o (pf_prefix),
      .is_rep_o    (pf_rep),
`ifdef ZET_IFETCH_LOCK_EN
      .is_lock_o   (pf_lock),
`endif
      .seg_valid_o (pf_seg_v),
      .seg_o       (pf_seg)
   );

   assign consume  = (state_q == S_OPC) || (state_q == S_MODRM && need_modrm) || (state_q == S_OFF_LO) ||
                     (state_q == S_OFF_HI) || (state_q == S_IMM_LO) || (state_q == S_IMM_HI);
   assign q_pop    = q_valid && consume && !flush && !rst;
   assign len_inc  = (len_q == 4'(MAX_LEN)) ? len_q : len_q + 4'd1;
   assign imm_nxt  = need_imm ? S_IMM_LO : S_EXEC;
   assign field_nxt = need_off ? S_OFF_LO : imm_nxt;

   always_comb begin
      state_d  = state_q;
      opcode_d = opcode_q;
      modrm_d  = modrm_q;
      off_d    = off_q;
      imm_d    = imm_q;
      rep_d    = rep_q;
      sop_d    = sop_q;
      len_d    = len_q;
`ifdef ZET_IFETCH_LOCK_EN
      lock_d   = lock_q;
`endif
      if (flush) begin
         state_d = S_OPC;
         modrm_d = 8'h00;
         off_d   = 16'h0000;
         imm_d   = 16'h0000;
         rep_d   = 1'b0;
         sop_d   = 3'b000;
         len_d   = 4'd0;
`ifdef ZET_IFETCH_LOCK_EN
         lock_d  = 1'b0;
`endif
      end else begin
         case (state_q)
            S_OPC: if (q_valid) begin
               len_d = len_inc;
               if (pf_prefix) begin
                  if (pf_rep) rep_d = 1'b1;
                  if (pf_seg_v) sop_d = {1'b1, pf_seg};
`ifdef ZET_IFETCH_LOCK_EN
                  if (pf_lock) lock_d = 1'b1;
`endif
               end else begin
                  opcode_d = q_byte;
                  modrm_d  = 8'h00;
                  off_d    = 16'h0000;
                  imm_d    = 16'h0000;
                  state_d  = S_MODRM;
               end
            end
            S_MODRM: if (!need_modrm) state_d = field_nxt;
               else if (q_valid) begin
                  modrm_d = q_byte;
                  len_d   = len_inc;
                  state_d = S_CHK;
               end
            // need_off is only valid once the fresh modrm has reached the decoder
            S_CHK: state_d = field_nxt;
            S_OFF_LO: if (q_valid) begin
               off_d   = {{8{q_byte[7]}}, q_byte};
               len_d   = len_inc;
               state_d = off_size ? S_OFF_HI : imm_nxt;
            end
            S_OFF_HI: if (q_valid) begin
               off_d   = {q_byte, off_q[7:0]};
               len_d   = len_inc;
               state_d = imm_nxt;
            end
            S_IMM_LO: if (q_valid) begin
               imm_d   = {{8{q_byte[7]}}, q_byte};
               len_d   = len_inc;
               state_d = imm_size ? S_IMM_HI : S_EXEC;
            end
            S_IMM_HI: if (q_valid) begin
               imm_d   = {q_byte, imm_q[7:0]};
               len_d   = len_inc;
               state_d = S_EXEC;
            end
            S_EXEC: if (end_seq && !block) begin
               state_d = S_OPC;
               rep_d   = 1'b0;
               sop_d   = 3'b000;
               len_d   = 4'd0;
`ifdef ZET_IFETCH_LOCK_EN
               lock_d  = 1'b0;
`endif
            end
            default: state_d = S_OPC;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_OPC;
         opcode_q <= 8'h00;
         modrm_q  <= 8'h00;
         off_q    <= 16'h0000;
         imm_q    <= 16'h0000;
         rep_q    <= 1'b0;
         sop_q    <= 3'b000;
         len_q    <= 4'd0;
`ifdef ZET_IFETCH_LOCK_EN
         lock_q   <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         opcode_q <= opcode_d;
         modrm_q  <= modrm_d;
         off_q    <= off_d;
         imm_q    <= imm_d;
         rep_q    <= rep_d;
         sop_q    <= sop_d;
         len_q    <= len_d;
`ifdef ZET_IFETCH_LOCK_EN
         lock_q   <= lock_d;
`endif
      end
   end

   assign opcode   = opcode_q;
   assign modrm    = modrm_q;
   assign off      = off_q;
   assign imm      = imm_q;
   assign rep      = rep_q;
   assign sop_l    = sop_q;
   assign inst_len = len_q;
   assign exec_st  = (state_q == S_EXEC);
endmodule

// File: tb/tb_zet_ifetch_asm.sv
// tb_zet_ifetch_asm: scoreboard bench for the instruction assembler.
module tb_zet_ifetch_asm;
   logic        clk = 1'b0;
   logic        rst, q_valid, q_pop, flush, need_modrm, need_off, need_imm, off_size, imm_size;
   logic        end_seq, block, rep, exec_st;
   logic [7:0]  q_byte, opcode, modrm;
   logic [15:0] off, imm;
   logic [2:0]  sop_l;
   logic [3:0]  inst_len;
`ifdef ZET_IFETCH_LOCK_EN
   logic        lock;
`endif

   always #5 clk = ~clk;

   zet_ifetch_asm dut (
      .clk        (clk),
      .rst        (rst),
      .q_byte     (q_byte),
      .q_valid    (q_valid),
      .q_pop      (q_pop),
      .flush      (flush),
      .need_modrm (need_modrm),
      .need_off   (need_off),
      .need_imm   (need_imm),
      .off_size   (off_size),
      .imm_size   (imm_size),
      .end_seq    (end_seq),
      .block      (block),
      .opcode     (opcode),
      .modrm      (modrm),
      .off        (off),
      .imm        (imm),
      .rep        (rep),
      .sop_l      (sop_l),
      .exec_st    (exec_st),
`ifdef ZET_IFETCH_LOCK_EN
      .lock       (lock),
`endif
      .inst_len   (inst_len)
   );

   typedef struct packed {
      logic [7:0]  opc;
      logic [7:0]  modrm;
      logic [15:0] off;
      logic [15:0] imm;
      logic        rep;
      logic [2:0]  sop;
      logic [3:0]  len;
   } exp_t;

   exp_t       sb[$];
   logic [7:0] stream[$];
   int         pos, n_chk, n_pass, bad_pop, cyc;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // Drives the stream byte by byte until EXEC, until stop pops, or the cycle budget runs out.
   task automatic feed(input int stop, input bit gap, output int n);
      bit ph = 1'b0;
      n = 0;
      forever begin
         @(negedge clk);
         if (exec_st || pos >= stop || n >= 200) break;
         ph = !ph;
         q_valid = (pos < stream.size()) && (!gap || ph);
         q_byte  = q_valid ? stream[pos] : 8'h00;
         #1;
         if (q_pop && !q_valid) bad_pop++;
         if (q_pop) pos++;
         n++;
      end
      q_valid = 1'b0;
      q_byte  = 8'h00;
   endtask

   task automatic run(input logic nm, input logic no, input logic ni, input logic os, input logic is,
                      input bit gap, input int exp_cyc);
      exp_t e, g;
      int   i;
      e = '0;
      i = 0;
      while (stream[i] inside {8'hF2, 8'hF3, 8'h26, 8'h2E, 8'h36, 8'h3E, 8'hF0}) begin
         if (stream[i] inside {8'hF2, 8'hF3}) e.rep = 1'b1;
         if (stream[i] inside {8'h26, 8'h2E, 8'h36, 8'h3E}) e.sop = {1'b1, stream[i][4:3]};
         i++;
      end
      e.opc = stream[i];
      i++;
      if (nm) begin
         e.modrm = stream[i];
         i++;
      end
      if (no) begin
         e.off = os ? {stream[i+1], stream[i]} : {{8{stream[i][7]}}, stream[i]};
         i += os ? 2 : 1;
      end
      if (ni) e.imm = is ? {stream[i+1], stream[i]} : {{8{stream[i][7]}}, stream[i]};
      e.len = (stream.size() > 15) ? 4'd15 : 4'(stream.size());
      sb.push_back(e);
      need_modrm = nm; need_off = no; need_imm = ni; off_size = os; imm_size = is;
      pos = 0;
      feed(1000, gap, cyc);
      check_eq("exec_st", exec_st, 1);
      check_eq("consumed", pos, stream.size());
      if (exp_cyc >= 0) check_eq("latency", cyc, exp_cyc);
      g = sb.pop_front();
      check_eq("opcode", opcode, g.opc);
      check_eq("modrm", modrm, g.modrm);
      check_eq("off", off, g.off);
      check_eq("imm", imm, g.imm);
      check_eq("rep", rep, g.rep);
      check_eq("sop_l", sop_l, g.sop);
      check_eq("inst_len", inst_len, g.len);
      q_valid = 1'b1; q_byte = 8'h90; block = 1'b1; end_seq = 1'b1;
      #1;
      check_eq("pop_in_exec", q_pop, 0);
      @(negedge clk);
      check_eq("block_hold", exec_st, 1);
      q_valid = 1'b0; block = 1'b0;
      @(negedge clk);
      end_seq = 1'b0;
      check_eq("end_exec", exec_st, 0);
      check_eq("end_rep", rep, 0);
      check_eq("end_sop", sop_l, 0);
      check_eq("end_len", inst_len, 0);
      check_eq("opcode_held", opcode, g.opc);
   endtask

   initial begin
      rst = 1'b1; q_valid = 1'b1; q_byte = 8'h90; flush = 1'b0; end_seq = 1'b0; block = 1'b0;
      need_modrm = 1'b0; need_off = 1'b0; need_imm = 1'b0; off_size = 1'b0; imm_size = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("rst_pop", q_pop, 0);
      check_eq("rst_fields", {opcode, modrm, rep, sop_l, exec_st, inst_len}, 0);
      check_eq("rst_off_imm", {off, imm}, 0);
      rst = 1'b0; q_valid = 1'b0;

      stream = '{8'h90};
      run(0, 0, 0, 0, 0, 0, 2);
      stream = '{8'h2E, 8'hF3, 8'hA5};
      run(0, 0, 0, 0, 0, 0, -1);
      stream = '{8'h8B, 8'h86, 8'hF0, 8'hFF};
      run(1, 1, 0, 1, 0, 0, -1);
      stream = '{8'h83, 8'hC0, 8'hFE};
      run(1, 0, 1, 0, 0, 0, -1);
      stream = '{8'h81, 8'hC0, 8'h34, 8'h12};
      run(1, 0, 1, 0, 1, 0, -1);
      stream = '{8'h8B, 8'h86, 8'hF0, 8'hFF};
      run(1, 1, 0, 1, 0, 1, -1);
      stream = '{8'h26, 8'hF2, 8'hC6, 8'h46, 8'hFE, 8'h7F};
      run(1, 1, 1, 0, 0, 1, -1);
      stream = '{8'hF0, 8'h90};
      run(0, 0, 0, 0, 0, 0, -1);

      // Abort an instruction while its high displacement byte is pending.
      stream = '{8'h36, 8'hF3, 8'h8B, 8'h86, 8'hF0, 8'hFF};
      need_modrm = 1; need_off = 1; off_size = 1; need_imm = 0; imm_size = 0;
      pos = 0;
      feed(5, 0, cyc);
      check_eq("pre_flush_sop", sop_l, 3'b110);
      q_valid = 1'b1; q_byte = 8'hFF; flush = 1'b1;
      #1;
      check_eq("flush_pop", q_pop, 0);
      @(negedge clk);
      flush = 1'b0; q_valid = 1'b0;
      check_eq("flush_state", {rep, sop_l, exec_st, inst_len}, 0);
      check_eq("flush_fields", {modrm, off}, 0);
      stream = '{8'h90};
      run(0, 0, 0, 0, 0, 0, 2);

      stream = {};
      repeat (16) stream.push_back(8'h26);
      stream.push_back(8'h90);
      run(0, 0, 0, 0, 0, 0, -1);

      check_eq("no_pop_invalid", bad_pop, 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
